// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures the fetched word, PC and fetch-exception flag,
// tracks delay-slot membership, and presents decoded fields to the decode stage.
module if_id_register #(
  parameter logic [31:0] RESET_PC   = 32'h00003000,
  parameter logic [31:0] HANDLER_PC = 32'h00004180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_F,
  input  logic [31:0] PCp4_F,
  input  logic        PCException_F,
  input  logic        FREEZE,
  input  logic        GOTO_HANDLER,
  input  logic        ERET,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCp4_D,
  output logic        valid_D,
  output logic        BD_D,
  output logic [31:0] EPC_cand_D,
  output logic [4:0]  ExcCode_D,
  output logic        exc_D,
  output logic [4:0]  rs_D,
  output logic [4:0]  rt_D,
  output logic [4:0]  rd_D,
  output logic [4:0]  shamt_D,
  output logic [15:0] imm16_D,
  output logic [31:0] sign_imm32_D,
  output logic [31:0] zero_imm32_D,
  output logic [25:0] addr26_D,
  output logic        is_branch_D
);

  logic [31:0] ir_q;
  logic [31:0] pc_q;
  logic        exc_q;
  logic        valid_q;
  logic        bd_q;
  logic        flush;
  logic        next_bd;

  assign flush = GOTO_HANDLER | ERET;

  // Handler-region code never marks its successor as a delay slot.
  assign next_bd = is_branch_D & valid_q & (pc_q < HANDLER_PC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q    <= '0;
      pc_q    <= RESET_PC;
      exc_q   <= 1'b0;
      valid_q <= 1'b0;
      bd_q    <= 1'b0;
    end else if (flush) begin
      ir_q    <= '0;
      pc_q    <= PCp4_F - 32'd4;
      exc_q   <= 1'b0;
      valid_q <= 1'b0;
      bd_q    <= 1'b0;
    end else if (!FREEZE) begin
      ir_q    <= PCException_F ? '0 : IR_F;
      pc_q    <= PCp4_F - 32'd4;
      exc_q   <= PCException_F;
      valid_q <= 1'b1;
      bd_q    <= next_bd;
    end
  end

  always_comb begin
    is_branch_D = 1'b0;
    case (ir_q[31:26])
      6'd0:    is_branch_D = (ir_q[5:0] == 6'd8) || (ir_q[5:0] == 6'd9);
      6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7:
               is_branch_D = 1'b1;
      default: is_branch_D = 1'b0;
    endcase
  end

  assign IR_D         = ir_q;
  assign PC_D         = pc_q;
  assign PCp4_D       = pc_q + 32'd4;
  assign valid_D      = valid_q;
  assign BD_D         = bd_q;
  assign exc_D        = exc_q;
  assign EPC_cand_D   = bd_q ? (pc_q - 32'd4) : pc_q;
  assign ExcCode_D    = exc_q ? 5'd4 : 5'd0;
  assign rs_D         = ir_q[25:21];
  assign rt_D         = ir_q[20:16];
  assign rd_D         = ir_q[15:11];
  assign shamt_D      = ir_q[10:6];
  assign imm16_D      = ir_q[15:0];
  assign sign_imm32_D = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zero_imm32_D = {16'h0000, ir_q[15:0]};
  assign addr26_D     = ir_q[25:0];

endmodule

// File: tb/tb_if_id_register.sv
// Bench for if_id_register: directed scenarios then random traffic, all outputs
// compared each cycle against a behavioural model of the stage.
module tb_if_id_register;

  localparam logic [31:0] RST_PC = 32'h00003000;
  localparam logic [31:0] HND_PC = 32'h00004180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] IR_F = '0;
  logic [31:0] PCp4_F = '0;
  logic        PCException_F = 1'b0;
  logic        FREEZE = 1'b0;
  logic        GOTO_HANDLER = 1'b0;
  logic        ERET = 1'b0;
  logic [31:0] IR_D, PC_D, PCp4_D, EPC_cand_D, sign_imm32_D, zero_imm32_D;
  logic        valid_D, BD_D, exc_D, is_branch_D;
  logic [4:0]  ExcCode_D, rs_D, rt_D, rd_D, shamt_D;
  logic [15:0] imm16_D;
  logic [25:0] addr26_D;

  int unsigned total = 0;
  int unsigned bad = 0;

  // model state
  logic [31:0] m_ir, m_pc;
  bit          m_valid, m_bd, m_exc;

  if_id_register #(.RESET_PC(RST_PC), .HANDLER_PC(HND_PC)) dut (
    .clk(clk), .reset(reset), .IR_F(IR_F), .PCp4_F(PCp4_F),
    .PCException_F(PCException_F), .FREEZE(FREEZE),
    .GOTO_HANDLER(GOTO_HANDLER), .ERET(ERET),
    .IR_D(IR_D), .PC_D(PC_D), .PCp4_D(PCp4_D), .valid_D(valid_D), .BD_D(BD_D),
    .EPC_cand_D(EPC_cand_D), .ExcCode_D(ExcCode_D), .exc_D(exc_D),
    .rs_D(rs_D), .rt_D(rt_D), .rd_D(rd_D), .shamt_D(shamt_D),
    .imm16_D(imm16_D), .sign_imm32_D(sign_imm32_D), .zero_imm32_D(zero_imm32_D),
    .addr26_D(addr26_D), .is_branch_D(is_branch_D)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_branch(input logic [31:0] ir);
    int unsigned op, funct;
    op    = ir / 32'h04000000;
    funct = ir % 64;
    return (op >= 1 && op <= 7) || (op == 0 && (funct == 8 || funct == 9));
  endfunction

  function automatic logic [31:0] field(input logic [31:0] ir, input int unsigned lo,
                                        input int unsigned w);
    return (ir >> lo) % (32'd1 << w);
  endfunction

  task automatic model_reset();
    m_ir = '0; m_pc = RST_PC; m_valid = 0; m_bd = 0; m_exc = 0;
  endtask

  task automatic model_edge();
    bit nbd;
    if (reset) model_reset();
    else if (GOTO_HANDLER || ERET) begin
      m_ir = '0; m_pc = PCp4_F - 4; m_valid = 0; m_bd = 0; m_exc = 0;
    end else if (!FREEZE) begin
      nbd     = model_branch(m_ir) && m_valid && (m_pc < HND_PC);
      m_ir    = PCException_F ? 32'd0 : IR_F;
      m_pc    = PCp4_F - 4;
      m_exc   = PCException_F;
      m_valid = 1;
      m_bd    = nbd;
    end
  endtask

  task automatic check_all();
    logic [31:0] imm;
    imm = field(m_ir, 0, 16);
    check("IR_D", IR_D, m_ir);
    check("PC_D", PC_D, m_pc);
    check("PCp4_D", PCp4_D, m_pc + 4);
    check("valid_D", 32'(valid_D), 32'(m_valid));
    check("BD_D", 32'(BD_D), 32'(m_bd));
    check("EPC_cand_D", EPC_cand_D, m_bd ? m_pc - 4 : m_pc);
    check("ExcCode_D", 32'(ExcCode_D), m_exc ? 32'd4 : 32'd0);
    check("exc_D", 32'(exc_D), 32'(m_exc));
    check("rs_D", 32'(rs_D), field(m_ir, 21, 5));
    check("rt_D", 32'(rt_D), field(m_ir, 16, 5));
    check("rd_D", 32'(rd_D), field(m_ir, 11, 5));
    check("shamt_D", 32'(shamt_D), field(m_ir, 6, 5));
    check("imm16_D", 32'(imm16_D), imm);
    check("sign_imm32_D", sign_imm32_D, imm >= 32'h8000 ? imm + 32'hFFFF0000 : imm);
    check("zero_imm32_D", zero_imm32_D, imm);
    check("addr26_D", 32'(addr26_D), field(m_ir, 0, 26));
    check("is_branch_D", 32'(is_branch_D), 32'(model_branch(m_ir)));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic load(input logic [31:0] ir, input logic [31:0] pcp4);
    IR_F = ir; PCp4_F = pcp4; PCException_F = 0;
    FREEZE = 0; GOTO_HANDLER = 0; ERET = 0;
    cycle();
  endtask

  logic [31:0] r, rir, next_pcp4;
  logic [5:0]  op, funct;

  initial begin
    // something loaded, then asynchronous reset mid-cycle
    load(32'h12345678, 32'h00001000);
    #2 reset = 1;
    #1 model_reset();
    check("rst_IR", IR_D, 32'h0);
    check("rst_PC", PC_D, 32'h00003000);
    check("rst_valid", 32'(valid_D), 32'h0);
    check("rst_BD", 32'(BD_D), 32'h0);
    check("rst_ExcCode", 32'(ExcCode_D), 32'h0);
    cycle();
    #3 reset = 0;

    load(32'h3C010001, 32'h00003004);
    check("lui_IR", IR_D, 32'h3C010001);
    check("lui_PC", PC_D, 32'h00003000);
    check("lui_rt", 32'(rt_D), 32'd1);
    check("lui_simm", sign_imm32_D, 32'h00000001);
    check("lui_valid", 32'(valid_D), 32'd1);
    check("lui_BD", 32'(BD_D), 32'd0);

    load(32'h10220003, 32'h0000300C);
    load(32'h00000000, 32'h00003010);
    check("slot_BD", 32'(BD_D), 32'd1);
    check("slot_EPC", EPC_cand_D, 32'h00003008);

    load(32'h10220003, 32'h00003014);
    FREEZE = 1;
    for (int i = 0; i < 3; i++) begin
      IR_F = 32'hA0000000 + 32'(i); PCp4_F = 32'h00005000 + 32'(4 * i);
      cycle();
      check("frz_IR", IR_D, 32'h10220003);
      check("frz_PC", PC_D, 32'h00003010);
    end
    GOTO_HANDLER = 1;
    cycle();
    check("flush_IR", IR_D, 32'h0);
    check("flush_valid", 32'(valid_D), 32'd0);
    check("flush_BD", 32'(BD_D), 32'd0);
    load(32'h00000000, 32'h00004184);
    check("post_flush_BD", 32'(BD_D), 32'd0);

    IR_F = 32'hFFFFFFFF; PCp4_F = 32'h00003006; PCException_F = 1;
    FREEZE = 0; GOTO_HANDLER = 0; ERET = 0;
    cycle();
    check("adel_IR", IR_D, 32'h0);
    check("adel_exc", 32'(exc_D), 32'd1);
    check("adel_code", 32'(ExcCode_D), 32'd4);
    check("adel_PC", PC_D, 32'h00003002);
    check("adel_valid", 32'(valid_D), 32'd1);

    load(32'h03E00008, 32'h00003008);
    check("jr_branch", 32'(is_branch_D), 32'd1);
    load(32'h03E0000A, 32'h0000300C);
    check("movz_branch", 32'(is_branch_D), 32'd0);

    // random traffic
    next_pcp4 = 32'h00003004;
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      op = 6'($urandom_range(0, 9));
      if (op > 6'd7) op = 6'($urandom());
      funct = 6'($urandom());
      if (op == 6'd0 && $urandom_range(0, 1) == 1) funct = 6'(8 + $urandom_range(0, 1));
      rir = {op, r[25:6], funct};
      if ($urandom_range(0, 15) == 0) rir = '0;
      if ($urandom_range(0, 19) == 0) next_pcp4 = $urandom();
      else if ($urandom_range(0, 29) == 0) next_pcp4 = HND_PC + 32'($urandom_range(0, 64));
      else if ($urandom_range(0, 49) == 0) next_pcp4 = 32'($urandom_range(0, 3));
      IR_F          = rir;
      PCp4_F        = next_pcp4;
      PCException_F = ($urandom_range(0, 15) == 0);
      FREEZE        = ($urandom_range(0, 3) == 0);
      GOTO_HANDLER  = ($urandom_range(0, 19) == 0);
      ERET          = ($urandom_range(0, 19) == 0);
      reset         = ($urandom_range(0, 63) == 0);
      if (!FREEZE) next_pcp4 = next_pcp4 + 4;
      cycle();
      #2 reset = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
